// File: rtl/startup_disp_pkg.sv
// Shared defaults, serializer state encoding and the fixed startup pattern table
// for the startup display pattern driver.
package startup_disp_pkg;

    localparam int DEF_NPAT     = 8;
    localparam int DEF_PAT_W    = 16;
    localparam int DEF_SCLK_DIV = 4;
    localparam int DEF_TMR_W    = 16;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_LATCH = 2'd2
    } ser_state_t;

    // Entry 0 is the blank pattern; the rest fill the panel in from both ends.
    function automatic logic [15:0] pat_lookup(input int unsigned idx);
        logic [15:0] pat;
        case (idx)
            0:       pat = 16'h0000;
            1:       pat = 16'h8001;
            2:       pat = 16'hC003;
            3:       pat = 16'hE007;
            4:       pat = 16'hF00F;
            5:       pat = 16'hF81F;
            6:       pat = 16'hFC3F;
            7:       pat = 16'hFFFF;
            default: pat = 16'h0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/disp_shift_out.sv
// Serializes one captured pattern MSB first to the display shift register,
// then pulses the latch; all outputs are registered.
module disp_shift_out
    import startup_disp_pkg::*;
#(
    parameter int PAT_W    = DEF_PAT_W,
    parameter int SCLK_DIV = DEF_SCLK_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [PAT_W-1:0] PATTERN,
    output logic             SCLK,
    output logic             SDAT,
    output logic             LATCH,
    output logic             BUSY
);

    localparam int PH_W  = (2 * SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [PH_W-1:0]  PH_HALF = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_W - 1);

    ser_state_t       state, state_n;
    logic [PAT_W-1:0] shreg, shreg_n;
    logic [BIT_W-1:0] bit_idx, bit_idx_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic             sclk_n, sdat_n, latch_n, busy_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= SER_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            phase   <= '0;
            SCLK    <= 1'b0;
            SDAT    <= 1'b0;
            LATCH   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            phase   <= phase_n;
            SCLK    <= sclk_n;
            SDAT    <= sdat_n;
            LATCH   <= latch_n;
            BUSY    <= busy_n;
        end
    end

    // Outputs are computed one cycle ahead so SDAT only moves on a low-phase start.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        phase_n   = phase;
        sclk_n    = SCLK;
        sdat_n    = SDAT;
        latch_n   = LATCH;
        busy_n    = BUSY;

        if (CLEAR) begin
            state_n   = SER_IDLE;
            shreg_n   = '0;
            bit_idx_n = '0;
            phase_n   = '0;
            sclk_n    = 1'b0;
            sdat_n    = 1'b0;
            latch_n   = 1'b0;
            busy_n    = 1'b0;
        end else begin
            unique case (state)
                SER_IDLE: begin
                    if (LOAD) begin
                        state_n   = SER_SHIFT;
                        shreg_n   = PATTERN;
                        bit_idx_n = BIT_TOP;
                        phase_n   = '0;
                        sclk_n    = 1'b0;
                        sdat_n    = PATTERN[PAT_W-1];
                        latch_n   = 1'b0;
                        busy_n    = 1'b1;
                    end
                end
                SER_SHIFT: begin
                    if (phase != PH_LAST) begin
                        phase_n = phase + PH_W'(1);
                        sclk_n  = (phase >= PH_HALF);
                    end else if (bit_idx == '0) begin
                        state_n = SER_LATCH;
                        shreg_n = '0;
                        phase_n = '0;
                        sclk_n  = 1'b0;
                        sdat_n  = 1'b0;
                        latch_n = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx - BIT_W'(1);
                        shreg_n   = shreg << 1;
                        phase_n   = '0;
                        sclk_n    = 1'b0;
                        sdat_n    = shreg[PAT_W-2];
                    end
                end
                SER_LATCH: begin
                    if (phase == PH_HALF) begin
                        state_n = SER_IDLE;
                        phase_n = '0;
                        latch_n = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        phase_n = phase + PH_W'(1);
                    end
                end
                default: begin
                    state_n = SER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/startup_pattern_driver.sv
// Datapath behind the startup display sequencer: timer, pattern address/DONE,
// pattern table lookup, display blanking and the serial display driver.
module startup_pattern_driver
    import startup_disp_pkg::*;
#(
    parameter int NPAT     = DEF_NPAT,
    parameter int PAT_W    = DEF_PAT_W,
    parameter int SCLK_DIV = DEF_SCLK_DIV,
    parameter int TMR_W    = DEF_TMR_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR,
    input  logic             DISP,
    input  logic             LOAD_PAT,
    input  logic             NXT_ADR,
    input  logic             RST_TMR,
    output logic [TMR_W-1:0] TMR,
    output logic             DONE,
    output logic             DSP_SCLK,
    output logic             DSP_SDAT,
    output logic             DSP_LATCH,
    output logic             DSP_BLANK,
    output logic             BUSY
);

    localparam int ADR_W = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(NPAT - 1);

    logic [ADR_W-1:0] adr;
    logic [PAT_W-1:0] pattern;

    // Saturating so a long wait never looks like a fresh count to the FSM.
    always_ff @(posedge CLK) begin
        if (RST || RST_TMR) begin
            TMR <= '0;
        end else if (TMR != '1) begin
            TMR <= TMR + TMR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            adr <= '0;
        end else if (CLEAR) begin
            adr <= '0;
        end else if (NXT_ADR && (adr < ADR_LAST)) begin
            adr <= adr + ADR_W'(1);
        end
    end

    // DONE lags ADR by a cycle; the FSM's skip state absorbs that delay.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DONE      <= 1'b0;
            DSP_BLANK <= 1'b1;
        end else begin
            DONE      <= (adr == ADR_LAST);
            DSP_BLANK <= ~DISP;
        end
    end

    always_comb begin
        pattern = PAT_W'(pat_lookup(32'(adr)));
    end

    disp_shift_out #(
        .PAT_W    (PAT_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_shift (
        .CLK     (CLK),
        .RST     (RST),
        .CLEAR   (CLEAR),
        .LOAD    (LOAD_PAT),
        .PATTERN (pattern),
        .SCLK    (DSP_SCLK),
        .SDAT    (DSP_SDAT),
        .LATCH   (DSP_LATCH),
        .BUSY    (BUSY)
    );

endmodule

// File: tb/tb_startup_pattern_driver.sv
// Directed self-checking bench for startup_pattern_driver: reset, timer,
// address/DONE, serial shifts, abort, collisions and mid-operation reset.
module tb_startup_pattern_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLEAR;
    logic        DISP;
    logic        LOAD_PAT;
    logic        NXT_ADR;
    logic        RST_TMR;
    logic [15:0] TMR;
    logic        DONE;
    logic        DSP_SCLK;
    logic        DSP_SDAT;
    logic        DSP_LATCH;
    logic        DSP_BLANK;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    startup_pattern_driver dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLEAR     (CLEAR),
        .DISP      (DISP),
        .LOAD_PAT  (LOAD_PAT),
        .NXT_ADR   (NXT_ADR),
        .RST_TMR   (RST_TMR),
        .TMR       (TMR),
        .DONE      (DONE),
        .DSP_SCLK  (DSP_SCLK),
        .DSP_SDAT  (DSP_SDAT),
        .DSP_LATCH (DSP_LATCH),
        .DSP_BLANK (DSP_BLANK),
        .BUSY      (BUSY)
    );

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic clear, input logic load, input logic nxt);
        CLEAR    = clear;
        LOAD_PAT = load;
        NXT_ADR  = nxt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Loads the pattern at the current address and scores the whole transfer.
    task automatic runShift(input logic [15:0] expected, input string tag, input int load_at);
        logic [15:0] bits = '0;
        int rises = 0;
        int busy_cyc = 0;
        int latch_cyc = 0;
        logic prev_sclk = 1'b0;
        logic last_bit = 1'b0;
        logic held_bad = 1'b0;
        logic early_latch = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_first_busy"}, 32'(BUSY), 32'd1);
        checkOutput({tag, "_first_sdat"}, 32'(DSP_SDAT), 32'(expected[15]));
        while (BUSY === 1'b1 && busy_cyc < 200) begin
            busy_cyc++;
            if (DSP_SCLK && !prev_sclk) begin
                bits     = {bits[14:0], DSP_SDAT};
                last_bit = DSP_SDAT;
                rises++;
            end else if (DSP_SCLK && prev_sclk && DSP_SDAT !== last_bit) begin
                held_bad = 1'b1;
            end
            if (DSP_LATCH) begin
                latch_cyc++;
                if (rises != 16) early_latch = 1'b1;
            end
            prev_sclk = DSP_SCLK;
            applyStimulus(1'b0, busy_cyc == load_at, 1'b0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd132);
        checkOutput({tag, "_sclk_rises"}, 32'(rises), 32'd16);
        checkOutput({tag, "_data"}, 32'(bits), 32'(expected));
        checkOutput({tag, "_latch_cycles"}, 32'(latch_cyc), 32'd4);
        checkOutput({tag, "_sdat_held_high"}, 32'(held_bad), 32'd0);
        checkOutput({tag, "_latch_order"}, 32'(early_latch), 32'd0);
        step();
        checkOutput({tag, "_idle_after"}, 32'(BUSY), 32'd0);
        checkOutput({tag, "_latch_low_after"}, 32'(DSP_LATCH), 32'd0);
    endtask

    initial begin
        int rises;
        int cyc;
        logic prev_sclk;
        logic seen_latch;
        logic seen_busy;

        // Reset with random FSM strobes.
        RST = 1'b1;
        RST_TMR = 1'b0;
        DISP = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            DISP    = 1'($urandom_range(0, 1));
            RST_TMR = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            checkOutput("rst_tmr", 32'(TMR), 32'd0);
            checkOutput("rst_done", 32'(DONE), 32'd0);
            checkOutput("rst_sclk", 32'(DSP_SCLK), 32'd0);
            checkOutput("rst_sdat", 32'(DSP_SDAT), 32'd0);
            checkOutput("rst_latch", 32'(DSP_LATCH), 32'd0);
            checkOutput("rst_busy", 32'(BUSY), 32'd0);
            checkOutput("rst_blank", 32'(DSP_BLANK), 32'd1);
        end
        RST = 1'b0;
        DISP = 1'b1;
        RST_TMR = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        checkOutput("blank_released", 32'(DSP_BLANK), 32'd0);
        checkOutput("tmr_held", 32'(TMR), 32'd0);

        // Timer count, restart and saturation.
        RST_TMR = 1'b0;
        repeat (3000) step();
        checkOutput("tmr_3000", 32'(TMR), 32'h0BB8);
        RST_TMR = 1'b1;
        step();
        checkOutput("tmr_restart", 32'(TMR), 32'd0);
        RST_TMR = 1'b0;
        repeat (65534) step();
        checkOutput("tmr_fffe", 32'(TMR), 32'hFFFE);
        step();
        checkOutput("tmr_ffff", 32'(TMR), 32'hFFFF);
        repeat (5) step();
        checkOutput("tmr_saturated", 32'(TMR), 32'hFFFF);
        RST_TMR = 1'b1;
        step();

        // Address walk to the last entry; DONE trails the address by one cycle.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            step();
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("done_after_pulse", 32'(DONE), 32'd0);
            step();
            checkOutput("done_settled", 32'(DONE), 32'(i == 7));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        checkOutput("done_saturated", 32'(DONE), 32'd1);
        runShift(16'hFFFF, "shift_adr7", -1);

        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("done_clear_edge", 32'(DONE), 32'd1);
        step();
        checkOutput("done_cleared", 32'(DONE), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        runShift(16'h8001, "shift_adr1", -1);

        // Abort after the fifth serial clock rise.
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        rises = 0;
        cyc = 0;
        prev_sclk = 1'b0;
        while (rises < 5 && cyc < 200) begin
            if (DSP_SCLK && !prev_sclk) rises++;
            prev_sclk = DSP_SCLK;
            if (rises < 5) begin
                step();
                cyc++;
            end
        end
        checkOutput("abort_reached_rise5", 32'(rises), 32'd5);
        checkOutput("abort_sclk_before", 32'(DSP_SCLK), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_sclk", 32'(DSP_SCLK), 32'd0);
        checkOutput("abort_sdat", 32'(DSP_SDAT), 32'd0);
        checkOutput("abort_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_latch", 32'(DSP_LATCH), 32'd0);
        seen_latch = 1'b0;
        seen_busy = 1'b0;
        repeat (150) begin
            step();
            seen_latch = seen_latch | DSP_LATCH;
            seen_busy = seen_busy | BUSY;
        end
        checkOutput("abort_no_latch", 32'(seen_latch), 32'd0);
        checkOutput("abort_stays_idle", 32'(seen_busy), 32'd0);
        runShift(16'h0000, "shift_adr0", -1);

        // LOAD_PAT mid-shift is dropped; CLEAR beats a same-cycle LOAD_PAT.
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        step();
        runShift(16'h8001, "collide", 50);
        applyStimulus(1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("clear_load_busy", 32'(BUSY), 32'd0);
        step();
        checkOutput("clear_load_busy_later", 32'(BUSY), 32'd0);

        DISP = 1'b0;
        step();
        checkOutput("blank_disp_low", 32'(DSP_BLANK), 32'd1);
        DISP = 1'b1;
        step();
        checkOutput("blank_disp_high", 32'(DSP_BLANK), 32'd0);

        // Reset in the middle of a shift with the timer running.
        applyStimulus(1'b0, 1'b0, 1'b1);
        RST_TMR = 1'b0;
        step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) step();
        checkOutput("midop_busy_before", 32'(BUSY), 32'd1);
        checkOutput("midop_tmr_before", 32'(TMR), 32'd12);
        RST = 1'b1;
        step();
        RST = 1'b0;
        checkOutput("midop_busy", 32'(BUSY), 32'd0);
        checkOutput("midop_sclk", 32'(DSP_SCLK), 32'd0);
        checkOutput("midop_sdat", 32'(DSP_SDAT), 32'd0);
        checkOutput("midop_tmr", 32'(TMR), 32'd0);
        checkOutput("midop_blank", 32'(DSP_BLANK), 32'd1);
        checkOutput("midop_done", 32'(DONE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
